truth_table_scanner: RTL and testbench

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

---
 rtl/truth_table_scanner.sv | 141 ++++++++++++++
 tb/tb_truth_table_scanner.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//   Walks a 4-input function under test through all 16 input vectors,
//   dwelling SETTLE_CYCLES cycles on each vector before sampling its output.
//   The sampled values are collected into a captured truth table and
//   compared against a golden table latched when the scan starts.
//
// Ports
//   clk            : single clock, rising edge
//   reset_n        : synchronous active-low reset
//   start          : one-cycle scan request, honoured only when idle
//   abort          : terminates a scan in progress (DRIVE or SAMPLE)
//   expected[15:0] : golden truth table, bit i = expected y for vector i
//   y              : output of the function under test
//   A, B, C, D     : stimulus, {D,C,B,A} = current vector index
//   busy           : high while a scan is in progress
//   done           : one-cycle pulse at scan completion
//   captured_table : sampled y per vector, bit i = y for vector i
//                    (named captured_table because "table" is a keyword)
//   err_count[4:0] : number of mismatching vectors, 0..16
//   pass           : last completed scan had no mismatches

module truth_table_scanner #(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    input  logic        y,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic [15:0] captured_table,
    output logic [4:0]  err_count,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] DWELL_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [3:0]  idx;
    logic [3:0]  dwell;
    logic [15:0] golden;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            idx            <= '0;
            dwell          <= '0;
            golden         <= '0;
            {D, C, B, A}   <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            captured_table <= '0;
            err_count      <= '0;
            pass           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort is meaningless here, so start always wins
                    if (start) begin
                        golden         <= expected;
                        captured_table <= '0;
                        err_count      <= '0;
                        pass           <= 1'b0;
                        idx            <= '0;
                        dwell          <= '0;
                        {D, C, B, A}   <= '0;
                        busy           <= 1'b1;
                        state          <= DRIVE;
                    end
                end

                DRIVE: begin
                    if (abort) begin
                        {D, C, B, A} <= '0;
                        busy         <= 1'b0;
                        pass         <= 1'b0;
                        state        <= IDLE;
                    end else if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        state <= SAMPLE;
                    end else begin
                        dwell <= dwell + 4'd1;
                    end
                end

                SAMPLE: begin
                    // an abort here drops the pending sample entirely
                    if (abort) begin
                        {D, C, B, A} <= '0;
                        busy         <= 1'b0;
                        pass         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        captured_table[idx] <= y;
                        // at most one increment per vector, so 16 is the ceiling
                        if (y != golden[idx]) begin
                            err_count <= err_count + 5'd1;
                        end
                        if (idx == 4'd15) begin
                            {D, C, B, A} <= '0;
                            busy         <= 1'b0;
                            state        <= DONE;
                        end else begin
                            idx          <= idx + 4'd1;
                            {D, C, B, A} <= idx + 4'd1;
                            dwell        <= '0;
                            state        <= DRIVE;
                        end
                    end
                end

                DONE: begin
                    // err_count already includes the final vector here
                    done         <= 1'b1;
                    pass         <= (err_count == 5'd0);
                    {D, C, B, A} <= '0;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner
//   Self-checking bench for truth_table_scanner with SETTLE_CYCLES = 3
//   (4 cycles per vector, done 65 cycles after the start edge).

module tb_truth_table_scanner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [15:0] expected;
    logic        y;
    logic        A, B, C, D;
    logic        busy;
    logic        done;
    logic [15:0] captured_table;
    logic [4:0]  err_count;
    logic        pass;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    truth_table_scanner #(.SETTLE_CYCLES(3)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .expected       (expected),
        .y              (y),
        .A              (A),
        .B              (B),
        .C              (C),
        .D              (D),
        .busy           (busy),
        .done           (done),
        .captured_table (captured_table),
        .err_count      (err_count),
        .pass           (pass)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: number of vectors where the captured value differs from gold
    function automatic logic [4:0] model_errs(input logic [15:0] got, input logic [15:0] gold);
        return 5'($countones(got ^ gold));
    endfunction

    // Runs one scan for 90 cycles after the start edge and reports what it saw.
    // ymode 0: y is the function func of the presented vector.
    // ymode 1: y is func[v] only in the sampling cycle of vector v, and keeps
    //          changing in every dwell cycle.
    // start_at/abort_at/reset_at: cycle index (after the start edge) at which
    // that input is driven for one edge; -1 disables.
    task automatic drive_scan(input logic [15:0] exp_v, input logic [15:0] func,
                              input int ymode, input int start_at, input int abort_at,
                              input int reset_at, input bit abort_with_start,
                              output int order_errs, output int done_at, output int done_count);
        order_errs = 0;
        done_at    = -1;
        done_count = 0;
        expected   = exp_v;
        start      = 1'b1;
        abort      = abort_with_start;
        y          = 1'b0;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int m = 0; m < 90; m++) begin
            bit         stopped;
            logic [3:0] ev;
            logic       eb;
            stopped = (abort_at >= 0 && m > abort_at) || (reset_at >= 0 && m > reset_at);
            if (!stopped && m < 64) begin
                ev = 4'(m / 4);
                eb = 1'b1;
            end else begin
                ev = 4'd0;
                eb = 1'b0;
            end
            if ({D, C, B, A} !== ev || busy !== eb) order_errs++;
            if (done === 1'b1) begin
                done_count++;
                if (done_at < 0) done_at = m;
            end
            start   = (m == start_at);
            abort   = (m == abort_at);
            reset_n = (m != reset_at);
            if (ymode == 0) begin
                y = func[{D, C, B, A}];
            end else if (m < 64) begin
                if (m % 4 == 3)      y = func[m / 4];
                else if (m % 4 == 2) y = ~func[m / 4];
                else                 y = ~y;
            end
            tick();
        end
        start   = 1'b0;
        abort   = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        y       = 1'b0;
        expected = '0;
        tick();
        tick();
        total_cnt++;
        if ({D, C, B, A, busy, done, pass} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0000000", {D, C, B, A, busy, done, pass});
        else pass_cnt++;
        total_cnt++;
        if (captured_table !== 16'h0000 || err_count !== 5'd0)
            $display("FAIL reset_regs: got table=%h err=%0d want 0000/0", captured_table, err_count);
        else pass_cnt++;
        reset_n = 1'b1;
        repeat (5) tick();
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_idle: got busy=%b done=%b want 0/0", busy, done);
        else pass_cnt++;
    endtask

    task automatic test_and4;
        int oe, da, dc;
        drive_scan(16'h8000, 16'h8000, 0, -1, -1, -1, 1'b0, oe, da, dc);
        total_cnt++;
        if (oe !== 0) $display("FAIL and4_order: got %0d bad cycles want 0", oe); else pass_cnt++;
        total_cnt++;
        if (da !== 65 || dc !== 1) $display("FAIL and4_done: got at=%0d count=%0d want 65/1", da, dc);
        else pass_cnt++;
        total_cnt++;
        if (captured_table !== 16'h8000 || err_count !== 5'd0 || pass !== 1'b1)
            $display("FAIL and4_result: got table=%h err=%0d pass=%b want 8000/0/1",
                     captured_table, err_count, pass);
        else pass_cnt++;
    endtask

    task automatic test_all_fail;
        int oe, da, dc;
        drive_scan(16'hFFFF, 16'h0000, 0, -1, -1, -1, 1'b0, oe, da, dc);
        total_cnt++;
        if (da !== 65 || dc !== 1) $display("FAIL allfail_done: got at=%0d count=%0d want 65/1", da, dc);
        else pass_cnt++;
        total_cnt++;
        if (captured_table !== 16'h0000 || err_count !== 5'd16 || pass !== 1'b0)
            $display("FAIL allfail_result: got table=%h err=%0d pass=%b want 0000/16/0",
                     captured_table, err_count, pass);
        else pass_cnt++;
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            int oe, da, dc;
            logic [15:0] func, gold;
            func = 16'($urandom);
            gold = (it == 0) ? func : 16'($urandom);
            drive_scan(gold, func, 0, -1, -1, -1, 1'b0, oe, da, dc);
            total_cnt++;
            if (oe !== 0 || da !== 65 || dc !== 1)
                $display("FAIL rand_timing[%0d]: got bad=%0d at=%0d count=%0d want 0/65/1", it, oe, da, dc);
            else pass_cnt++;
            total_cnt++;
            if (captured_table !== func)
                $display("FAIL rand_table[%0d]: got %h want %h", it, captured_table, func);
            else pass_cnt++;
            total_cnt++;
            if (err_count !== model_errs(func, gold) || pass !== (model_errs(func, gold) == 5'd0))
                $display("FAIL rand_err[%0d]: got err=%0d pass=%b want %0d/%b", it, err_count, pass,
                         model_errs(func, gold), model_errs(func, gold) == 5'd0);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_ignored;
        int oe, da, dc;
        logic [15:0] func, gold;
        func = 16'($urandom);
        gold = 16'($urandom);
        drive_scan(gold, func, 0, 28, -1, -1, 1'b0, oe, da, dc);
        total_cnt++;
        if (oe !== 0 || da !== 65 || dc !== 1)
            $display("FAIL busy_start: got bad=%0d at=%0d count=%0d want 0/65/1", oe, da, dc);
        else pass_cnt++;
        total_cnt++;
        if (captured_table !== func || err_count !== model_errs(func, gold))
            $display("FAIL busy_start_result: got %h/%0d want %h/%0d", captured_table, err_count,
                     func, model_errs(func, gold));
        else pass_cnt++;
    endtask

    task automatic test_abort;
        int oe, da, dc;
        logic [15:0] func, gold, part;
        func = 16'($urandom);
        gold = 16'($urandom);
        part = func & 16'h001F;
        drive_scan(gold, func, 0, -1, 20, -1, 1'b0, oe, da, dc);
        total_cnt++;
        if (oe !== 0 || dc !== 0)
            $display("FAIL abort_stop: got bad=%0d done_count=%0d want 0/0", oe, dc);
        else pass_cnt++;
        total_cnt++;
        if (captured_table !== part || err_count !== model_errs(part, gold & 16'h001F) || pass !== 1'b0)
            $display("FAIL abort_partial: got %h/%0d/%b want %h/%0d/0", captured_table, err_count, pass,
                     part, model_errs(part, gold & 16'h001F));
        else pass_cnt++;
        // abort while idle leaves the retained results alone
        abort = 1'b1;
        repeat (3) tick();
        abort = 1'b0;
        total_cnt++;
        if (captured_table !== part || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_idle: got %h busy=%b done=%b want %h/0/0", captured_table, busy, done, part);
        else pass_cnt++;
        drive_scan(gold, func, 0, -1, -1, -1, 1'b0, oe, da, dc);
        total_cnt++;
        if (oe !== 0 || da !== 65 || captured_table !== func)
            $display("FAIL abort_restart: got bad=%0d at=%0d table=%h want 0/65/%h", oe, da, captured_table, func);
        else pass_cnt++;
    endtask

    task automatic test_abort_in_done;
        int oe, da, dc;
        logic [15:0] func;
        func = 16'($urandom);
        drive_scan(func, func, 0, -1, 64, -1, 1'b0, oe, da, dc);
        total_cnt++;
        if (da !== 65 || dc !== 1 || pass !== 1'b1)
            $display("FAIL abort_done: got at=%0d count=%0d pass=%b want 65/1/1", da, dc, pass);
        else pass_cnt++;
    endtask

    task automatic test_abort_with_start;
        int oe, da, dc;
        logic [15:0] func, gold;
        func = 16'($urandom);
        gold = 16'($urandom);
        drive_scan(gold, func, 0, -1, -1, -1, 1'b1, oe, da, dc);
        total_cnt++;
        if (oe !== 0 || da !== 65 || captured_table !== func)
            $display("FAIL start_abort: got bad=%0d at=%0d table=%h want 0/65/%h", oe, da, captured_table, func);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int oe, da, dc;
        logic [15:0] func;
        func = 16'($urandom) | 16'h0001;
        drive_scan(~func, func, 0, -1, -1, 40, 1'b0, oe, da, dc);
        total_cnt++;
        if (oe !== 0 || dc !== 0)
            $display("FAIL midreset_stop: got bad=%0d done_count=%0d want 0/0", oe, dc);
        else pass_cnt++;
        total_cnt++;
        if (captured_table !== 16'h0000 || err_count !== 5'd0 || pass !== 1'b0)
            $display("FAIL midreset_regs: got %h/%0d/%b want 0000/0/0", captured_table, err_count, pass);
        else pass_cnt++;
    endtask

    task automatic test_y_toggle;
        for (int it = 0; it < 3; it++) begin
            int oe, da, dc;
            logic [15:0] func, gold;
            func = 16'($urandom);
            gold = 16'($urandom);
            drive_scan(gold, func, 1, -1, -1, -1, 1'b0, oe, da, dc);
            total_cnt++;
            if (captured_table !== func || err_count !== model_errs(func, gold) || da !== 65)
                $display("FAIL ytoggle[%0d]: got %h/%0d at=%0d want %h/%0d at=65", it, captured_table,
                         err_count, da, func, model_errs(func, gold));
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_and4();
        test_all_fail();
        test_random();
        test_start_ignored();
        test_abort();
        test_abort_in_done();
        test_abort_with_start();
        test_reset_mid();
        test_y_toggle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
